// File: rtl/fpdiv_iter.sv
// Iterative single-precision divider: Newton-Raphson reciprocal on one shared multiplier, then quotient multiply.
// Fixed 8-cycle accept-to-valid latency; one operation in flight; result held until out_ready.

module fprecip_rom #(
   parameter int LUT_BITS = 7
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [LUT_BITS-1:0] i_addr,
   output logic [7:0]          o_x0
);

   logic [7:0] w_rom [0:(1<<LUT_BITS)-1];

   // Entry g holds round(2/d_mid * 256) - 256, with d_mid taken at the bucket centre.
   for (genvar g = 0; g < (1 << LUT_BITS); g++) begin : g_rom
      localparam int D = (1 << (LUT_BITS + 1)) + 2 * g + 1;
      localparam int Y = ((1 << (LUT_BITS + 10)) + D / 2) / D;
      assign w_rom[g] = 8'(Y - 256);
   end

   always_ff @(posedge clk) begin
      if (!rst) o_x0 <= '0;
      else      o_x0 <= w_rom[i_addr];
   end

endmodule

module fpdiv_iter #(
   parameter int MW       = 26,
   parameter int LUT_BITS = 7
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] num,
   input  logic [31:0] denom,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] quot
);

   typedef enum logic [3:0] {
      S_IDLE, S_ROM, S_NR1M, S_NR1X, S_NR2M, S_NR2X, S_QMUL, S_NORM, S_DONE
   } state_t;

   state_t r_state, w_next;

   logic [31:0]       r_num, r_den, r_quot;
   logic [25:0]       r_t;
   logic [17:0]       r_x1;
   logic [24:0]       r_x2;
   logic [48:0]       r_q;
   logic              r_out_valid;

   logic [7:0]        w_x0;
   logic [MW-1:0]     w_mul_a, w_mul_b;
   logic [2*MW-1:0]   w_prod;
   logic [24:0]       w_p1, w_c1;
   logic [25:0]       w_p2, w_c2, w_x2r;
   logic [24:0]       w_x2;
   logic [24:0]       w_mr;
   logic signed [9:0] w_adj, w_e;
   logic [22:0]       w_frac;
   logic              w_sign;
   logic [31:0]       w_res;
   logic              w_unused;

   fprecip_rom #(.LUT_BITS(LUT_BITS)) u_rom (
      .clk    (clk),
      .rst    (rst),
      .i_addr (r_den[22:22-LUT_BITS+1]),
      .o_x0   (w_x0)
   );

   always_ff @(posedge clk) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (in_valid) w_next = S_ROM;
         S_ROM:   w_next = S_NR1M;
         S_NR1M:  w_next = S_NR1X;
         S_NR1X:  w_next = S_NR2M;
         S_NR2M:  w_next = S_NR2X;
         S_NR2X:  w_next = S_QMUL;
         S_QMUL:  w_next = S_NORM;
         S_NORM:  w_next = S_DONE;
         S_DONE:  if (r_out_valid && out_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Reciprocal estimates are kept as Y = 2/d so that Y sits in (1,2] with a leading one.
   always_comb begin
      w_mul_a = '0;
      w_mul_b = '0;
      case (r_state)
         S_NR1M: begin w_mul_a = MW'({1'b1, r_den[22:0]}); w_mul_b = MW'({1'b1, w_x0}); end
         S_NR1X: begin w_mul_a = MW'(r_t[24:0]);           w_mul_b = MW'({1'b1, w_x0}); end
         S_NR2M: begin w_mul_a = MW'({1'b1, r_den[22:0]}); w_mul_b = MW'(r_x1);         end
         S_NR2X: begin w_mul_a = MW'(r_x1);                w_mul_b = MW'(r_t);          end
         S_QMUL: begin w_mul_a = MW'({1'b1, r_num[22:0]}); w_mul_b = MW'(r_x2);         end
         default: ;
      endcase
   end

   assign w_prod = {{MW{1'b0}}, w_mul_a} * {{MW{1'b0}}, w_mul_b};

   assign w_p1  = w_prod[32:8] + 25'(w_prod[7]);
   assign w_c1  = ~w_p1 + 25'd1;
   assign w_p2  = w_prod[40:15] + 26'(w_prod[14]);
   assign w_c2  = ~w_p2 + 26'd1;
   assign w_x2r = {1'b0, w_prod[41:17]} + 26'(w_prod[16]);
   // Y2 only reaches 2.0 for d == 1.0; saturating keeps 24 fraction bits for every other divisor.
   assign w_x2  = (w_prod[43:42] != 2'b00 || w_x2r[25]) ? '1 : w_x2r[24:0];

   always_comb begin
      w_sign = r_num[31] ^ r_den[31];
      if (r_q[48]) w_mr = {1'b0, r_q[48:25]} + 25'(r_q[24]);
      else         w_mr = {1'b0, r_q[47:24]} + 25'(r_q[23]);
      w_adj  = (r_q[48] ? 10'sd0 : -10'sd1) + (w_mr[24] ? 10'sd1 : 10'sd0);
      w_e    = $signed({2'b00, r_num[30:23]}) - $signed({2'b00, r_den[30:23]}) + 10'sd127 + w_adj;
      w_frac = w_mr[24] ? 23'd0 : w_mr[22:0];
      if (r_den[30:23] == 8'd0)       w_res = {w_sign, 8'hFF, 23'd0};
      else if (r_num[30:23] == 8'd0)  w_res = {w_sign, 31'd0};
      else if (w_e >= 10'sd255)       w_res = {w_sign, 8'hFF, 23'd0};
      else if (w_e <= 10'sd0)         w_res = {w_sign, 31'd0};
      else                            w_res = {w_sign, w_e[7:0], w_frac};
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_num       <= '0;
         r_den       <= '0;
         r_t         <= '0;
         r_x1        <= '0;
         r_x2        <= '0;
         r_q         <= '0;
         r_quot      <= '0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (in_valid) begin
               r_num <= num;
               r_den <= denom;
            end
            S_NR1M:  r_t   <= {1'b0, w_c1};
            S_NR1X:  r_x1  <= w_prod[33:16];
            S_NR2M:  r_t   <= w_c2;
            S_NR2X:  r_x2  <= w_x2;
            S_QMUL:  r_q   <= w_prod[48:0];
            S_NORM:  r_quot <= w_res;
            default: ;
         endcase
         // Valid rises one cycle into DONE and drops on the accepting edge.
         r_out_valid <= (r_state == S_DONE) && !(r_out_valid && out_ready);
      end
   end

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = r_out_valid;
   assign quot      = r_quot;

   assign w_unused = ^{w_prod[2*MW-1:49], r_q[22:0]};

endmodule

// File: tb/tb_fpdiv_iter.sv
// Directed and swept checks of fpdiv_iter: latency, special cases, backpressure, mid-operation reset.
module tb_fpdiv_iter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic [31:0] num = '0;
   logic [31:0] denom = '0;
   logic        in_ready;
   logic        out_valid;
   logic [31:0] quot;

   int n_chk  = 0;
   int n_pass = 0;

   fpdiv_iter dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .num       (num),
      .denom     (denom),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .quot      (quot)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp,
                      input int tol = 0);
      logic ok;
      int   d;
      n_chk++;
      if (tol == 0) begin
         ok = (got === exp);
      end else begin
         d  = int'({1'b0, got[30:0]}) - int'({1'b0, exp[30:0]});
         ok = (got[31] === exp[31]) && (d <= tol) && (d >= -tol);
      end
      if (ok) n_pass++;
      else $display("FAIL %s: got %h expected %h (tol %0d)", tag, got, exp, tol);
   endtask

   // Integer long-division reference, correctly rounded (half-up).
   function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
      logic [63:0] na, nb, q, mr;
      int e;
      na = {40'd0, 1'b1, a[22:0]};
      nb = {40'd0, 1'b1, b[22:0]};
      e  = int'(a[30:23]) - int'(b[30:23]) + 127;
      if (na >= nb) begin
         q = (na << 24) / nb;
      end else begin
         q = (na << 25) / nb;
         e = e - 1;
      end
      mr = (q + 64'd1) >> 1;
      if (mr == 64'h100_0000) begin
         mr = 64'h80_0000;
         e  = e + 1;
      end
      return {a[31] ^ b[31], 8'(e), mr[22:0]};
   endfunction

   // Called at a negedge; returns at the negedge right after the accepting posedge.
   task automatic start_op(input logic [31:0] a, input logic [31:0] b);
      int n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("accept_ready", {31'd0, in_ready}, 32'd1);
      num      = a;
      denom    = b;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      num      = $urandom;
      denom    = $urandom;
   endtask

   task automatic wait_result(output logic [31:0] q, output int lat);
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      q = quot;
   endtask

   task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp, input int tol);
      logic [31:0] q;
      int lat;
      start_op(a, b);
      wait_result(q, lat);
      chk(tag, q, exp, tol);
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] q, a, b;
      int lat, seen;

      repeat (3) @(negedge clk);
      chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_quot",      quot,               32'd0);
      rst = 1'b1;
      @(negedge clk);

      start_op(32'h3F800000, 32'h40000000);
      wait_result(q, lat);
      chk("latency",       32'(lat), 32'd8);
      chk("one_over_two",  q,        32'h3F000000);
      @(negedge clk);
      chk("taken_valid",   {31'd0, out_valid}, 32'd0);
      chk("taken_ready",   {31'd0, in_ready},  32'd1);

      run("six_three",     32'h40C00000, 32'h40400000, 32'h40000000, 0);
      run("neg_six_three", 32'hC0C00000, 32'h40400000, 32'hC0000000, 0);
      run("one_third",     32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1);
      run("div_by_zero",   32'h40000000, 32'h00000000, 32'h7F800000, 0);
      run("neg_div_zero",  32'hC0000000, 32'h00000000, 32'hFF800000, 0);
      run("zero_by_zero",  32'h00000000, 32'h00000000, 32'h7F800000, 0);
      run("zero_num",      32'h00000000, 32'h40400000, 32'h00000000, 0);
      run("overflow",      32'h7F000000, 32'h00800000, 32'h7F800000, 0);
      run("underflow",     32'h00800000, 32'h7F000000, 32'h00000000, 0);
      run("seven_half",    32'h40E00000, 32'h3F000000, 32'h41600000, 0);

      // Consumer stalls for five cycles while stray operands are offered.
      out_ready = 1'b0;
      start_op(32'h40C00000, 32'h40400000);
      wait_result(q, lat);
      chk("bp_latency", 32'(lat), 32'd8);
      chk("bp_result",  q,        32'h40000000);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         num      = 32'h3F800000;
         denom    = 32'h40000000;
         @(negedge clk);
         chk("bp_valid", {31'd0, out_valid}, 32'd1);
         chk("bp_quot",  quot,               32'h40000000);
         chk("bp_ready", {31'd0, in_ready},  32'd0);
      end
      out_ready = 1'b1;
      num       = 32'hC0C00000;
      denom     = 32'h40400000;
      @(negedge clk);
      chk("bp_drop_valid", {31'd0, out_valid}, 32'd0);
      chk("bp_idle_ready", {31'd0, in_ready},  32'd1);
      start_op(32'hC0C00000, 32'h40400000);
      wait_result(q, lat);
      chk("bp_next_lat",    32'(lat), 32'd8);
      chk("bp_next_result", q,        32'hC0000000);
      @(negedge clk);

      // Reset pulse while the second Newton step is multiplying.
      start_op(32'h3F800000, 32'h40400000);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      chk("midrst_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst_ready", {31'd0, in_ready},  32'd1);
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk("midrst_stale", 32'(seen), 32'd0);
      run("after_rst", 32'h40C00000, 32'h40400000, 32'h40000000, 0);

      for (int i = 0; i < 3000; i++) begin
         a = {1'($urandom_range(0, 1)), 8'($urandom_range(80, 174)), 23'($urandom)};
         b = {1'($urandom_range(0, 1)), 8'($urandom_range(80, 174)), 23'($urandom)};
         run("rand", a, b, ref_div(a, b), 1);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
